// File: rtl/redis_cmd_deserializer_if.sv
// Byte-stream input, assembled command bus and error pulse of the Redis command deserializer.
// The deserializer uses the slave modport; the host/cache side uses master.
interface redis_cmd_deserializer_if #(
  parameter int CMD_WIDTH   = 8,
  parameter int KEY_WIDTH   = 64,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32
);
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   cmd_valid;
  logic [CMD_WIDTH-1:0]   cmd_opcode;
  logic [KEY_WIDTH-1:0]   cmd_key;
  logic [VALUE_WIDTH-1:0] cmd_value;
  logic [TTL_WIDTH-1:0]   cmd_ttl;
  logic                   cmd_ready;
  logic                   err_valid;
  logic [1:0]             err_code;

  modport slave (
    input  in_valid, in_data, cmd_ready,
    output in_ready, cmd_valid, cmd_opcode, cmd_key, cmd_value, cmd_ttl,
           err_valid, err_code
  );

  modport master (
    output in_valid, in_data, cmd_ready,
    input  in_ready, cmd_valid, cmd_opcode, cmd_key, cmd_value, cmd_ttl,
           err_valid, err_code
  );
endinterface

// File: rtl/redis_cmd_deserializer.sv
// Assembles GET/SET/DEL byte frames into a parallel command with a valid/ready handshake.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module redis_cmd_deserializer #(
  parameter int         KEY_WIDTH      = 64,
  parameter int         VALUE_WIDTH    = 64,
  parameter int         TTL_WIDTH      = 32,
  parameter int         CMD_WIDTH      = 8,
  parameter logic [7:0] OP_GET         = 8'h01,
  parameter logic [7:0] OP_SET         = 8'h02,
  parameter logic [7:0] OP_DEL         = 8'h03,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  redis_cmd_deserializer_if.slave bus
);

  localparam int KEY_BYTES   = KEY_WIDTH / 8;
  localparam int VALUE_BYTES = VALUE_WIDTH / 8;
  localparam int TTL_BYTES   = TTL_WIDTH / 8;
  localparam int MAX_KV      = (KEY_BYTES > VALUE_BYTES) ? KEY_BYTES : VALUE_BYTES;
  localparam int MAX_BYTES   = (MAX_KV > TTL_BYTES) ? MAX_KV : TTL_BYTES;
  localparam int CNT_W       = $clog2(MAX_BYTES) + 1;

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] VALUE_LAST = CNT_W'(VALUE_BYTES - 1);
  localparam logic [CNT_W-1:0] TTL_LAST   = CNT_W'(TTL_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_KEY, S_VALUE, S_TTL, S_ISSUE} state_t;

  state_t                 state, state_next;
  logic [7:0]             opcode_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;
  logic [TTL_WIDTH-1:0]   ttl_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   err_valid_q;
  logic [1:0]             err_code_q, err_code_next;
  logic                   accept, is_op, timeout_hit;
  logic                   load_op, shift_key, shift_value, shift_ttl, cnt_clear, err_fire;

  assign accept = bus.in_valid && bus.in_ready;
  assign is_op  = (bus.in_data == OP_GET) || (bus.in_data == OP_SET) || (bus.in_data == OP_DEL);

`ifdef CMD_TIMEOUT_EN
  logic [31:0] idle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (accept || timeout_hit || state == S_IDLE || state == S_ISSUE)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 32'd1;
  end

  assign timeout_hit = (state == S_KEY || state == S_VALUE || state == S_TTL) && !accept &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    load_op       = 1'b0;
    shift_key     = 1'b0;
    shift_value   = 1'b0;
    shift_ttl     = 1'b0;
    cnt_clear     = 1'b0;
    err_fire      = 1'b0;
    err_code_next = err_code_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_op) begin
            load_op    = 1'b1;
            cnt_clear  = 1'b1;
            state_next = S_KEY;
          end else begin
            err_fire      = 1'b1;
            err_code_next = 2'b01;
          end
        end
      end
      S_KEY: begin
        if (accept) begin
          shift_key = 1'b1;
          if (cnt_q == KEY_LAST) begin
            cnt_clear  = 1'b1;
            state_next = (opcode_q == OP_SET) ? S_VALUE : S_ISSUE;
          end
        end
      end
      S_VALUE: begin
        if (accept) begin
          shift_value = 1'b1;
          if (cnt_q == VALUE_LAST) begin
            cnt_clear  = 1'b1;
            state_next = S_TTL;
          end
        end
      end
      S_TTL: begin
        if (accept) begin
          shift_ttl = 1'b1;
          if (cnt_q == TTL_LAST) begin
            cnt_clear  = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A stalled partial frame is abandoned; the stale fields are cleared by the next opcode.
    if (timeout_hit) begin
      state_next    = S_IDLE;
      cnt_clear     = 1'b1;
      err_fire      = 1'b1;
      err_code_next = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= '0;
      key_q       <= '0;
      value_q     <= '0;
      ttl_q       <= '0;
      cnt_q       <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      err_valid_q <= err_fire;
      err_code_q  <= err_code_next;
      if (cnt_clear)
        cnt_q <= '0;
      else if (shift_key || shift_value || shift_ttl)
        cnt_q <= cnt_q + 1'b1;
      if (load_op) begin
        opcode_q <= bus.in_data;
        key_q    <= '0;
        value_q  <= '0;
        ttl_q    <= '0;
      end
      if (shift_key)
        key_q <= (key_q << 8) | KEY_WIDTH'(bus.in_data);
      if (shift_value)
        value_q <= (value_q << 8) | VALUE_WIDTH'(bus.in_data);
      if (shift_ttl)
        ttl_q <= (ttl_q << 8) | TTL_WIDTH'(bus.in_data);
    end
  end

  assign bus.in_ready   = (state != S_ISSUE);
  assign bus.cmd_valid  = (state == S_ISSUE);
  assign bus.cmd_opcode = CMD_WIDTH'(opcode_q);
  assign bus.cmd_key    = key_q;
  assign bus.cmd_value  = value_q;
  assign bus.cmd_ttl    = ttl_q;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_redis_cmd_deserializer.sv
// Scoreboard bench for redis_cmd_deserializer: directed test-plan frames plus random frames,
// checked by an independent monitor against expectations built from the frame fields.
module tb_redis_cmd_deserializer;
  localparam int KW = 64;
  localparam int VW = 64;
  localparam int TW = 32;
  localparam int CW = 8;
`ifdef CMD_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif
  localparam logic [7:0] OP_GET = 8'h01;
  localparam logic [7:0] OP_SET = 8'h02;
  localparam logic [7:0] OP_DEL = 8'h03;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  redis_cmd_deserializer_if #(.CMD_WIDTH(CW), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW)) bus();

  redis_cmd_deserializer #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW), .CMD_WIDTH(CW),
    .OP_GET(OP_GET), .OP_SET(OP_SET), .OP_DEL(OP_DEL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [7:0]  op;
    logic [63:0] key;
    logic [63:0] value;
    logic [31:0] ttl;
    int          start;
    int          len;
  } exp_cmd_t;

  typedef struct {
    logic [1:0] code;
    int         at;
  } exp_err_t;

  exp_cmd_t cmd_q[$];
  exp_err_t err_q[$];
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  bit rand_ready = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int pickGap(input int maxgap);
    if (maxgap <= 0) return 0;
    return int'($urandom_range(0, maxgap));
  endfunction

  // Drive one byte and return the cycle in which it was accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap, output int acc);
    int waited = 0;
    @(negedge clk);
    if (gap > 0) repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_wait: got 0 expected 1 within 500 cycles");
    end
    acc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic sendFrame(input logic [7:0] op, input logic [63:0] key, input logic [63:0] value,
                           input logic [31:0] ttl, input int maxgap, input int stall_len);
    int acc;
    exp_cmd_t e;
    applyStimulus(op, pickGap(maxgap), acc);
    stall_cnt = stall_len;
    for (int i = 0; i < KW / 8; i++) applyStimulus(8'(key >> (8 * (KW / 8 - 1 - i))), pickGap(maxgap), acc);
    if (op == OP_SET) begin
      for (int i = 0; i < VW / 8; i++) applyStimulus(8'(value >> (8 * (VW / 8 - 1 - i))), pickGap(maxgap), acc);
      for (int i = 0; i < TW / 8; i++) applyStimulus(8'(ttl >> (8 * (TW / 8 - 1 - i))), pickGap(maxgap), acc);
    end
    e.op    = op;
    e.key   = key;
    e.value = (op == OP_SET) ? value : 64'd0;
    e.ttl   = (op == OP_SET) ? ttl : 32'd0;
    e.start = acc + 1;
    e.len   = (stall_len > 0) ? stall_len + 1 : 0;
    cmd_q.push_back(e);
  endtask

  task automatic sendBad(input logic [7:0] b, input int gap);
    int acc;
    exp_err_t e;
    applyStimulus(b, gap, acc);
    e.code = 2'b01;
    e.at   = acc + 1;
    err_q.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
    checkOutput({tag, "_err_valid"}, 64'(bus.err_valid), 64'd0);
    checkOutput({tag, "_err_code"}, 64'(bus.err_code), 64'd0);
    checkOutput({tag, "_opcode"}, 64'(bus.cmd_opcode), 64'd0);
    checkOutput({tag, "_key"}, bus.cmd_key, 64'd0);
    checkOutput({tag, "_value"}, bus.cmd_value, 64'd0);
    checkOutput({tag, "_ttl"}, 64'(bus.cmd_ttl), 64'd0);
  endtask

  // Downstream ready: optional stall count while a command is presented, else random or always-ready.
  initial begin
    bus.cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0 && bus.cmd_valid) begin
        bus.cmd_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready)
        bus.cmd_ready = ($urandom_range(0, 3) != 0);
      else
        bus.cmd_ready = 1'b1;
    end
  end

  // Monitor: compares every presented command and error pulse with the scoreboard head.
  initial begin
    int  len = 0;
    bit  prev_hs = 1'b0;
    exp_err_t ee;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        len = 0;
        prev_hs = 1'b0;
        continue;
      end
      if (prev_hs) checkOutput("in_ready_after_handshake", 64'(bus.in_ready), 64'd1);
      prev_hs = 1'b0;
      if (bus.cmd_valid) begin
        checkOutput("in_ready_during_issue", 64'(bus.in_ready), 64'd0);
        checkOutput("err_in_issue", 64'(bus.err_valid), 64'd0);
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_cmd: got cmd_valid=1 expected no command (cycle %0d)", cyc);
        end else begin
          len++;
          if (len == 1) checkOutput("cmd_latency", 64'(cyc), 64'(cmd_q[0].start));
          checkOutput("cmd_opcode", 64'(bus.cmd_opcode), 64'(CW'(cmd_q[0].op)));
          checkOutput("cmd_key", bus.cmd_key, cmd_q[0].key);
          checkOutput("cmd_value", bus.cmd_value, cmd_q[0].value);
          checkOutput("cmd_ttl", 64'(bus.cmd_ttl), 64'(cmd_q[0].ttl));
          if (bus.cmd_ready) begin
            if (cmd_q[0].len != 0) checkOutput("cmd_valid_cycles", 64'(len), 64'(cmd_q[0].len));
            void'(cmd_q.pop_front());
            len = 0;
            prev_hs = 1'b1;
          end
        end
      end
      if (bus.err_valid) begin
        if (err_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_err: got err_valid=1 code %0b expected none (cycle %0d)", bus.err_code, cyc);
        end else begin
          ee = err_q.pop_front();
          checkOutput("err_code", 64'(bus.err_code), 64'(ee.code));
          checkOutput("err_cycle", 64'(cyc), 64'(ee.at));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int waited;
    logic [7:0] op;
    logic [7:0] b;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    sendFrame(OP_SET, 64'h0001020304050607, 64'h1112131415161718, 32'h0000003C, 0, 0);
    sendFrame(OP_GET, 64'hAAAAAAAAAAAAAAAA, 64'd0, 32'd0, 0, 0);
    sendFrame(OP_DEL, 64'hDEADBEEFCAFEF00D, 64'd0, 32'd0, 0, 5);
    sendBad(8'h7F, 0);
    sendFrame(OP_GET, 64'h0123456789ABCDEF, 64'd0, 32'd0, 0, 0);

    // Abandon a SET after four key bytes with a reset, then issue a GET.
    applyStimulus(OP_SET, 0, acc);
    for (int i = 0; i < 4; i++) applyStimulus(8'hC0 + 8'(i), 0, acc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sendFrame(OP_GET, 64'h5555AAAA5555AAAA, 64'd0, 32'd0, 0, 0);

    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do b = 8'($urandom); while (b == OP_GET || b == OP_SET || b == OP_DEL);
        sendBad(b, pickGap(3));
      end else begin
        case ($urandom_range(0, 2))
          0: op = OP_GET;
          1: op = OP_SET;
          default: op = OP_DEL;
        endcase
        sendFrame(op, {$urandom, $urandom}, {$urandom, $urandom}, $urandom, 3, 0);
      end
    end
    rand_ready = 1'b0;

`ifdef CMD_TIMEOUT_EN
    begin
      exp_err_t te;
      waited = 0;
      while (cmd_q.size() != 0 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      applyStimulus(OP_SET, 0, acc);
      for (int i = 0; i < 3; i++) applyStimulus(8'h40 + 8'(i), 0, acc);
      te.code = 2'b10;
      te.at   = acc + TO + 1;
      err_q.push_back(te);
      repeat (TO + 5) @(negedge clk);
      sendFrame(OP_GET, 64'h1122334455667788, 64'd0, 32'd0, 0, 0);
    end
`endif

    waited = 0;
    while ((cmd_q.size() != 0 || err_q.size() != 0) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    checkOutput("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    checkOutput("err_queue_drained", 64'(err_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
